// File: rtl/game_input_if.sv
// game_input_if: player buttons, timer handshake and display outputs of game_input_ctrl
interface game_input_if #(
  parameter int N_BTN   = 4,
  parameter int SCORE_W = 8
);
  logic               btn_start;
  logic [N_BTN-1:0]   btn;
  logic               game_fail;
  logic               start;
  logic               miss;
  logic [N_BTN-1:0]   target_led;
  logic [SCORE_W-1:0] score;
  logic [1:0]         state;
  modport master (output btn_start, btn, game_fail, input start, miss, target_led, score, state);
  modport slave  (input btn_start, btn, game_fail, output start, miss, target_led, score, state);
endinterface

// File: rtl/game_input_ctrl.sv
// game_input_ctrl: debounced button front end and game FSM driving the countdown timer
module game_input_ctrl #(
  parameter int         N_BTN           = 4,
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         TARGET_TIMEOUT  = 50000000,
  parameter int         MISS_HOLD       = 5001,
  parameter int         SCORE_W         = 8,
  parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
  input logic         clock,
  input logic         reset_n,
  game_input_if.slave io
);
  localparam int LW = $clog2(N_BTN);
  localparam int NB = N_BTN + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TARGET_TIMEOUT + 1);
  localparam int HW = $clog2(MISS_HOLD + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, OVER = 2'b10} state_t;
  logic [NB-1:0]      raw, s1, s2, db, db_d, pr;
  logic [DW-1:0]      dc [NB];
  logic [7:0]         lfsr;
  state_t             st;
  logic               start_r;
  logic [N_BTN-1:0]   led;
  logic [SCORE_W-1:0] score;
  logic [LW-1:0]      tgt, cand, new_tgt;
  logic [N_BTN-1:0]   tgt_oh, new_oh, lane_press;
  logic [TW-1:0]      cnt;
  logic               start_press, live, hit, wrong, tout, ev, leave;
  logic [3:0]         pend, pend_nx;
  logic               win, end_w;
  logic [HW-1:0]      hc;
  assign raw = {io.btn_start, io.btn};
  // pr is a one-cycle pulse registered one cycle after the debounced rising edge
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      pr   <= '0;
      for (int i = 0; i < NB; i++) dc[i] <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_d <= db;
      pr   <= db & ~db_d;
      for (int i = 0; i < NB; i++) begin
        db[i] <= (s2[i] != db[i] && dc[i] == DW'(DEBOUNCE_CYCLES - 1)) ? s2[i] : db[i];
        dc[i] <= (s2[i] == db[i] || dc[i] == DW'(DEBOUNCE_CYCLES - 1)) ? '0 : dc[i] + 1'b1;
      end
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign lane_press  = pr[N_BTN-1:0];
  assign start_press = pr[N_BTN];
  assign cand        = lfsr[LW-1:0];
  assign new_tgt     = (cand == tgt) ? cand + LW'(1) : cand;
  assign tgt_oh      = N_BTN'(1) << tgt;
  assign new_oh      = N_BTN'(1) << new_tgt;
  // game_fail outranks any press; a press outranks the timeout
  assign live  = st == RUN && !io.game_fail;
  assign hit   = live && lane_press == tgt_oh;
  assign wrong = live && lane_press != '0 && !hit;
  assign tout  = live && lane_press == '0 && cnt == TW'(TARGET_TIMEOUT - 1);
  assign ev    = wrong || tout;
  assign leave = (st == RUN && io.game_fail) || (st == OVER && start_press);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      st      <= IDLE;
      start_r <= 1'b0;
      led     <= '0;
      score   <= '0;
      tgt     <= '0;
      cnt     <= '0;
    end else begin
      case (st)
        IDLE: if (start_press) begin
          st      <= RUN;
          start_r <= 1'b1;
          score   <= '0;
          tgt     <= new_tgt;
          led     <= new_oh;
          cnt     <= '0;
        end
        RUN: if (io.game_fail) begin
          st      <= OVER;
          start_r <= 1'b0;
          led     <= '1;
          cnt     <= '0;
        end else if (hit || tout) begin
          score <= (hit && score != '1) ? score + 1'b1 : score;
          tgt   <= new_tgt;
          led   <= new_oh;
          cnt   <= '0;
        end else begin
          cnt <= wrong ? '0 : cnt + 1'b1;
        end
        OVER: if (start_press) begin
          st  <= IDLE;
          led <= '0;
        end
        default: st <= IDLE;
      endcase
    end
  // each pending miss becomes one MISS_HOLD-long window; windows chain without a gap
  assign end_w   = win && hc == HW'(MISS_HOLD - 1);
  assign pend_nx = (ev && end_w) ? pend :
                   ev ? pend + {3'b0, pend != 4'hF} :
                   end_w ? pend - 4'd1 : pend;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pend <= '0;
      win  <= 1'b0;
      hc   <= '0;
    end else if (leave) begin
      pend <= '0;
      win  <= 1'b0;
      hc   <= '0;
    end else begin
      pend <= pend_nx;
      win  <= end_w ? pend_nx != '0 : win || pend != '0;
      hc   <= (end_w || !win) ? '0 : hc + 1'b1;
    end
  assign io.start      = start_r;
  assign io.miss       = win;
  assign io.target_led = led;
  assign io.score      = score;
  assign io.state      = st;
endmodule

// File: tb/tb_game_input_ctrl.sv
// tb_game_input_ctrl: table rows, directed corner sequences and random rounds against a round-level model
module tb_game_input_ctrl;
  localparam int N = 4, D = 4, TO = 20, MH = 6, SW = 8;
  localparam int K_START = 0, K_HIT = 1, K_WRONG = 2, K_MULTI = 3, K_TOUT = 4, K_BOUNCE = 5, K_FAIL = 6;
  typedef struct {int k; int st; int score; int mc;} vec_t;
  logic clock = 1'b0, reset_n = 1'b0;
  int cyc, n_vec = 0, n_bad = 0;
  int mcount = 0;
  int m_st, m_score, m_tgt, m_u, m_ev;
  logic [7:0] lfs [20000];
  vec_t tbl [9];
  always #5 clock = ~clock;
  game_input_if #(.N_BTN(N), .SCORE_W(SW)) io();
  game_input_ctrl #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .TARGET_TIMEOUT(TO), .MISS_HOLD(MH),
    .SCORE_W(SW), .LFSR_SEED(8'hA5)) dut (.clock(clock), .reset_n(reset_n), .io(io));
  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;
  always @(negedge clock) if (io.miss === 1'b1) mcount <= mcount + 1;
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end
  task automatic chk(input string nm, input int a, input int e);
    n_vec++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask
  // lfs[j] is the LFSR value after j clock edges since reset release
  function automatic int nt(input int u);
    int c;
    c = int'(lfs[u-1]) % N;
    return (c == m_tgt) ? (c + 1) % N : c;
  endfunction
  task automatic advance(input int t);
    while (m_st == 1 && m_u + TO <= t) begin
      m_tgt = nt(m_u + TO);
      m_u  += TO;
      m_ev++;
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_score = 0; m_tgt = 0; m_u = 0;
  endtask
  task automatic check_all(input string tag);
    advance(cyc);
    chk({tag, "_state"}, int'(io.state), m_st);
    chk({tag, "_score"}, int'(io.score), m_score);
    chk({tag, "_led"}, int'(io.target_led), m_st == 1 ? (1 << m_tgt) : m_st == 2 ? 15 : 0);
    chk({tag, "_start"}, int'(io.start), m_st == 1 ? 1 : 0);
  endtask
  // one round: press rounds hold the raw input D+4 cycles and release it D+4 cycles
  task automatic act(input int k);
    int c0, p, a, b;
    logic [N-1:0] v;
    logic s;
    if (k == K_TOUT) begin
      advance(cyc);
      wait_until(m_u + TO + MH + 3);
    end else begin
      c0 = (k == K_BOUNCE) ? cyc + 20 : cyc;
      p  = c0 + D + 4;
      advance(p - 1);
      a = $urandom_range(N - 1);
      b = (a + 1 + $urandom_range(N - 2)) % N;
      v = '0;
      s = 1'b0;
      case (k)
        K_START: s = 1'b1;
        K_HIT, K_BOUNCE, K_FAIL: v[m_tgt] = 1'b1;
        K_WRONG: v[(m_tgt + 1 + $urandom_range(N - 2)) % N] = 1'b1;
        default: begin v[a] = 1'b1; v[b] = 1'b1; end
      endcase
      if (m_st == 1 && k == K_FAIL) m_st = 2;
      else if (m_st == 1 && v == (N'(1) << m_tgt)) begin
        m_score = (m_score == 255) ? 255 : m_score + 1;
        m_tgt = nt(p);
        m_u = p;
      end else if (m_st == 1 && v != '0) begin
        m_ev++;
        m_u = p;
      end else if (m_st == 0 && s) begin
        m_st = 1; m_score = 0; m_tgt = nt(p); m_u = p;
      end else if (m_st == 2 && s) m_st = 0;
      if (k == K_BOUNCE)
        for (int i = 0; i < 10; i++) begin
          io.btn = (i % 2 == 1) ? '0 : v;
          step(2);
        end
      io.btn = v;
      io.btn_start = s;
      step(D + 3);
      io.game_fail = (k == K_FAIL);
      step(1);
      io.game_fail = 1'b0;
      io.btn = '0;
      io.btn_start = 1'b0;
      step(D + 4);
    end
    check_all("round");
  endtask
  initial begin
    int mc0, ev0, run, n;
    logic [N-1:0] led0;
    io.btn = '0;
    io.btn_start = 1'b0;
    io.game_fail = 1'b0;
    lfs[0] = 8'hA5;
    for (int i = 1; i < 20000; i++)
      lfs[i] = {lfs[i-1][6:0], lfs[i-1][7] ^ lfs[i-1][5] ^ lfs[i-1][4] ^ lfs[i-1][3]};
    tbl[0] = '{K_START,  1, 0, 0};
    tbl[1] = '{K_HIT,    1, 1, 0};
    tbl[2] = '{K_WRONG,  1, 1, MH};
    tbl[3] = '{K_MULTI,  1, 1, MH};
    tbl[4] = '{K_TOUT,   1, 1, MH};
    tbl[5] = '{K_BOUNCE, 1, 2, MH};
    tbl[6] = '{K_FAIL,   2, 2, 0};
    tbl[7] = '{K_START,  0, 2, 0};
    tbl[8] = '{K_START,  1, 0, 0};
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    step(3);
    chk("reset_miss", int'(io.miss), 0);
    check_all("reset");
    for (int i = 0; i < 9; i++) begin
      mc0 = mcount;
      led0 = io.target_led;
      act(tbl[i].k);
      chk("tbl_state", int'(io.state), tbl[i].st);
      chk("tbl_score", int'(io.score), tbl[i].score);
      chk("tbl_miss_cycles", mcount - mc0, tbl[i].mc);
      chk("tbl_miss_low", int'(io.miss), 0);
      if (tbl[i].k == K_HIT) chk("hit_new_target", int'(io.target_led != led0), 1);
    end
    // wrong lane held, then two more lanes together: two misses, windows back to back
    advance(cyc);
    led0 = io.target_led;
    io.btn = '0;
    io.btn[(m_tgt + 1) % N] = 1'b1;
    step(2);
    io.btn[(m_tgt + 2) % N] = 1'b1;
    io.btn[(m_tgt + 3) % N] = 1'b1;
    m_ev += 2;
    m_u = cyc - 2 + D + 4 + 2;
    n = 0;
    while (io.miss !== 1'b1 && n < 30) begin step(1); n++; end
    run = 0;
    while (io.miss === 1'b1 && run < 40) begin run++; step(1); end
    chk("miss_run", run, 2 * MH);
    chk("miss_target_kept", int'(io.target_led), int'(led0));
    io.btn = '0;
    step(D + 4);
    act(K_HIT);
    reset_n = 1'b0;
    #2;
    chk("areset_state", int'(io.state), 0);
    chk("areset_score", int'(io.score), 0);
    chk("areset_led", int'(io.target_led), 0);
    chk("areset_start", int'(io.start), 0);
    chk("areset_miss", int'(io.miss), 0);
    model_reset();
    @(negedge clock) reset_n = 1'b1;
    step(2);
    act(K_START);
    mc0 = mcount;
    ev0 = m_ev;
    for (int i = 0; i < 40; i++) begin
      n = $urandom_range(4);
      act(n == 4 ? K_HIT : n);
    end
    for (int i = 0; i < 300 && m_score < 255; i++) act(K_HIT);
    act(K_HIT);
    act(K_HIT);
    chk("score_saturated", int'(io.score), 255);
    act(K_FAIL);
    chk("miss_total", mcount - mc0, (m_ev - ev0) * MH);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
